// File: rtl/alu_opa_stage_pkg.sv
// Shared codes and defaults for the ALU operand-A stage.
package alu_opa_stage_pkg;

   localparam int unsigned XLEN_DEFAULT  = 32;
   localparam int unsigned REGAW_DEFAULT = 5;

   // Operand source select codes (3 is reserved and resolves to zero).
   typedef enum logic [1:0] {
      SEL_RS1  = 2'd0,
      SEL_PC   = 2'd1,
      SEL_ZERO = 2'd2,
      SEL_RSVD = 2'd3
   } sel_t;

   // Origin of the resolved operand.
   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_EXM  = 2'd1,
      FWD_MWB  = 2'd2
   } fwd_t;

   // Skid buffer occupancy.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_opa_stage_fwd_resolve.sv
// Combinational operand-A source selection with EX/MEM > MEM/WB forwarding.
module opa_fwd_resolve
   import alu_opa_stage_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned REGAW = REGAW_DEFAULT
) (
   input  logic [1:0]       sel,
   input  logic [REGAW-1:0] rs1_addr,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  pc,
   input  logic             exm_wen,
   input  logic [REGAW-1:0] exm_rd,
   input  logic [XLEN-1:0]  exm_data,
   input  logic             mwb_wen,
   input  logic [REGAW-1:0] mwb_rd,
   input  logic [XLEN-1:0]  mwb_data,
   output logic [XLEN-1:0]  data_c,
   output logic [1:0]       fwd_c
);

   // Register x0 never forwards; EX/MEM is the younger result and wins.
   always_comb begin
      data_c = '0;
      fwd_c  = FWD_NONE;
      case (sel)
         SEL_PC: data_c = pc;
         SEL_RS1: begin
            if (rs1_addr != '0) begin
               if (exm_wen && (exm_rd == rs1_addr)) begin
                  data_c = exm_data;
                  fwd_c  = FWD_EXM;
               end else if (mwb_wen && (mwb_rd == rs1_addr)) begin
                  data_c = mwb_data;
                  fwd_c  = FWD_MWB;
               end else begin
                  data_c = rs1_data;
               end
            end
         end
         default: data_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_opa_stage.sv
// ALU operand-A stage: resolve at accept, hold in a 2-entry skid buffer.
module alu_opa_stage
   import alu_opa_stage_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned REGAW = REGAW_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       sel,
   input  logic [REGAW-1:0] rs1_addr,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  pc,
   input  logic             exm_wen,
   input  logic [REGAW-1:0] exm_rd,
   input  logic [XLEN-1:0]  exm_data,
   input  logic             mwb_wen,
   input  logic [REGAW-1:0] mwb_rd,
   input  logic [XLEN-1:0]  mwb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  opa,
   output logic [1:0]       fwd_src
);

   logic [XLEN-1:0] res_data;
   logic [1:0]      res_fwd;
   state_t          state;
   logic [XLEN-1:0] skid_data;
   logic [1:0]      skid_fwd;
   logic            accept;
   logic            drain;

   opa_fwd_resolve #(
      .XLEN  (XLEN),
      .REGAW (REGAW)
   ) u_resolve (
      .sel      (sel),
      .rs1_addr (rs1_addr),
      .rs1_data (rs1_data),
      .pc       (pc),
      .exm_wen  (exm_wen),
      .exm_rd   (exm_rd),
      .exm_data (exm_data),
      .mwb_wen  (mwb_wen),
      .mwb_rd   (mwb_rd),
      .mwb_data (mwb_data),
      .data_c   (res_data),
      .fwd_c    (res_fwd)
   );

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   // Head entry lives directly in opa/fwd_src; second entry waits in the skid regs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         opa       <= '0;
         fwd_src   <= FWD_NONE;
         skid_data <= '0;
         skid_fwd  <= FWD_NONE;
      end else if (flush) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               in_ready <= 1'b1;
               if (accept) begin
                  opa       <= res_data;
                  fwd_src   <= res_fwd;
                  out_valid <= 1'b1;
                  state     <= ST_HALF;
               end
            end
            ST_HALF: begin
               if (accept && drain) begin
                  opa     <= res_data;
                  fwd_src <= res_fwd;
               end else if (accept) begin
                  skid_data <= res_data;
                  skid_fwd  <= res_fwd;
                  in_ready  <= 1'b0;
                  state     <= ST_FULL;
               end else if (drain) begin
                  out_valid <= 1'b0;
                  state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  opa      <= skid_data;
                  fwd_src  <= skid_fwd;
                  in_ready <= 1'b1;
                  state    <= ST_HALF;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_opa_stage.md
ALU_OPA_STAGE -- requirements
Module: alu_opa_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of every data port.
REQ-002 Parameter REGAW, default 5, register-file address width.
REQ-003 Clock: one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  synchronous discard of all buffered operands.
REQ-007 in_valid  in  1  upstream offers an operand request.
REQ-008 in_ready  out  1  stage can accept a request this cycle.
REQ-009 sel  in  2  source select: 0 RS1, 1 PC, 2 ZERO, 3 reserved.
REQ-010 rs1_addr  in  REGAW  source register index.
REQ-011 rs1_data  in  XLEN  register-file read value.
REQ-012 pc  in  XLEN  instruction address.
REQ-013 exm_wen / exm_rd / exm_data  in  1 / REGAW / XLEN  EX/MEM writeback candidate.
REQ-014 mwb_wen / mwb_rd / mwb_data  in  1 / REGAW / XLEN  MEM/WB writeback candidate.
REQ-015 out_valid  out  1  opa holds a valid operand.
REQ-016 out_ready  in  1  downstream ALU consumes opa this cycle.
REQ-017 opa  out  XLEN  resolved ALU operand A.
REQ-018 fwd_src  out  2  origin of opa: 0 none, 1 EX/MEM, 2 MEM/WB.

Function
REQ-019 Operand SHALL be resolved combinationally at accept (in_valid & in_ready) and stored; no later input change affects a stored entry.
REQ-020 sel=PC -> pc; sel=ZERO or sel=3 -> all-zero; fwd_src 0.
REQ-021 sel=RS1, rs1_addr=0 -> all-zero, fwd_src 0, regardless of rs1_data or forwarding matches.
REQ-022 sel=RS1, rs1_addr!=0: exm_wen & exm_rd==rs1_addr -> exm_data, fwd_src 1; else mwb_wen & mwb_rd==rs1_addr -> mwb_data, fwd_src 2; else rs1_data, fwd_src 0.
REQ-023 EX/MEM match SHALL take priority over MEM/WB match when both hit.
REQ-024 Storage: 2-entry skid buffer, FIFO order, states EMPTY, HALF, FULL.
REQ-025 in_ready = 1 in EMPTY and HALF, 0 in FULL; SHALL NOT depend combinationally on out_ready.
REQ-026 out_valid = 1 in HALF and FULL; opa/fwd_src present the oldest entry.
REQ-027 Latency: accepted request appears on opa with out_valid the next cycle; sustained throughput one per cycle when out_ready=1.
REQ-028 Transitions: EMPTY+accept -> HALF; HALF+accept+drain -> HALF (new entry shown); HALF+accept only -> FULL; HALF+drain only -> EMPTY; FULL+drain -> HALF (second entry shown); otherwise hold.
REQ-029 Drain with out_valid=0 SHALL have no effect; opa held stable while out_valid=1 and out_ready=0.
REQ-030 flush SHALL dominate: next state EMPTY, concurrent accept discarded, concurrent drain ignored.

Reset
REQ-031 rst_n low SHALL immediately force state EMPTY, out_valid 0, opa 0, fwd_src 0, in_ready 0.
REQ-032 in_ready SHALL rise to 1 in the first cycle after rst_n deasserts; reset mid-transfer loses all buffered entries.

Structure
REQ-033 Shared package holds: sel codes, fwd_src codes, state enum, XLEN/REGAW defaults.
REQ-034 One sub-module opa_fwd_resolve SHALL contain the purely combinational selection/forwarding of REQ-020..023; buffer control stays in alu_opa_stage.

Verification
REQ-035 sel=RS1, rs1_addr=5, exm_wen=1 exm_rd=5 exm_data=0xAAAA0001, mwb_wen=1 mwb_rd=5 mwb_data=0xBBBB0002 -> opa=0xAAAA0001, fwd_src=1 one cycle later.
REQ-036 sel=RS1, rs1_addr=0, rs1_data=0xDEADBEEF, exm_rd=0 exm_wen=1 -> opa=0, fwd_src=0.
REQ-037 Three back-to-back accepts (pc=0x100, 0x104, 0x108, sel=PC) with out_ready=0 -> in_ready drops after second; releasing out_ready yields 0x100, 0x104, then third accepted and delivered, no loss or duplication.
REQ-038 FULL state, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, no entry delivered.
REQ-039 rst_n asserted asynchronously mid-cycle in HALF -> out_valid, opa, in_ready go 0 without a clock edge; first post-reset accept delivered normally.
REQ-040 Random stimulus, XLEN=64, scoreboard vs. reference model -> order and values match for 10k transactions.
